// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types, default widths and output-stage constants for the FIR MAC engine
package fir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FINAL,
    ST_DONE
  } fir_state_t;

  localparam int FIR_DATA_SIZE = 16;
  localparam int FIR_COEF_SIZE = 32;
  localparam int FIR_COEF_FRAC = 16;
  localparam int FIR_ACC_SIZE  = 56;

  localparam longint SAT_MIN = 0;

  // Half an output LSB in accumulator units, for round-half-up.
  function automatic longint rnd_const(input int frac);
    return longint'(1) <<< (frac - 1);
  endfunction

  function automatic longint sat_max(input int dsz);
    return (longint'(1) <<< dsz) - 1;
  endfunction

endpackage

// File: rtl/fir_mac_slice.sv
// rtl/fir_mac_slice.sv - registered signed multiply followed by full-precision accumulate
module fir_mac_slice #(
  parameter int A_W   = 17,
  parameter int B_W   = 32,
  parameter int ACC_W = 56
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [A_W+B_W-1:0] prod;
  logic                      prod_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else begin
      prod_vld <= en;
      if (en)
        prod <= (A_W+B_W)'(a) * (A_W+B_W)'(b);
      if (clr)
        acc <= '0;
      else if (prod_vld)
        acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/fir_mac_engine.sv
// rtl/fir_mac_engine.sv - FIR core: sequences tap addresses, MACs sample x coef, rounds and saturates
module fir_mac_engine
  import fir_pkg::*;
#(
  parameter int M         = 23,
  parameter int ADDR_SIZE = 5,
  parameter int DATA_SIZE = FIR_DATA_SIZE,
  parameter int COEF_SIZE = FIR_COEF_SIZE,
  parameter int COEF_FRAC = FIR_COEF_FRAC,
  parameter int RD_LAT    = 1,
  parameter int ACC_SIZE  = FIR_ACC_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 dc_en,
  input  logic                 mem_owe,
  output logic [ADDR_SIZE-1:0] xant_addr,
  input  logic [DATA_SIZE-1:0] xant_q,
  output logic [ADDR_SIZE-1:0] coef_addr,
  input  logic [COEF_SIZE-1:0] coef_q,
  output logic                 busy,
  output logic                 idle,
  output logic                 done,
  output logic [DATA_SIZE-1:0] result
);

  localparam int W   = ACC_SIZE + 2;
  localparam int DCW = $clog2(RD_LAT + 3);
  localparam logic signed [W-1:0] RND  = W'(rnd_const(COEF_FRAC));
  localparam logic signed [W-1:0] OFFS = W'(longint'(1) <<< (DATA_SIZE - 1));
  localparam logic signed [W-1:0] YMAX = W'(sat_max(DATA_SIZE));
  localparam logic signed [W-1:0] YMIN = W'(SAT_MIN);
  localparam logic signed [DATA_SIZE:0] SOFF = (DATA_SIZE+1)'(1) << (DATA_SIZE - 1);

  fir_state_t                  state, state_nxt;
  logic [ADDR_SIZE-1:0]        addr;
  logic [DCW-1:0]              drain_cnt;
  logic [RD_LAT-1:0]           rd_vld;
  logic                        dc_lat;
  logic                        accept, last_addr, drain_last;
  logic signed [DATA_SIZE:0]   samp;
  logic signed [ACC_SIZE-1:0]  acc;
  logic signed [W-1:0]         y_rnd, y_off;
  logic [DATA_SIZE-1:0]        y_sat;

  assign xant_addr  = addr;
  assign coef_addr  = addr;
  assign accept     = (state == ST_IDLE) && start && !mem_owe;
  assign last_addr  = (addr == ADDR_SIZE'(M - 1));
  assign drain_last = (drain_cnt == DCW'(RD_LAT + 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    idle      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        idle = 1'b1;
        if (start && !mem_owe) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_addr) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (drain_last) state_nxt = ST_FINAL;
      end
      ST_FINAL: begin
        busy      = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // rd_vld tracks which cycle the BRAM data for an issued tap address is on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      dc_lat    <= 1'b0;
      drain_cnt <= '0;
      rd_vld    <= '0;
      result    <= '0;
    end else begin
      if (accept) begin
        addr   <= '0;
        dc_lat <= dc_en;
      end else if (state == ST_RUN && !last_addr) begin
        addr <= addr + ADDR_SIZE'(1);
      end
      if (state == ST_DRAIN) drain_cnt <= drain_cnt + DCW'(1);
      else                   drain_cnt <= '0;
      rd_vld[0] <= (state == ST_RUN);
      for (int i = 1; i < RD_LAT; i++) rd_vld[i] <= rd_vld[i-1];
      if (state == ST_FINAL) result <= y_sat;
    end
  end

  always_comb begin
    samp = $signed({1'b0, xant_q});
    if (dc_lat) samp = samp - SOFF;
  end

  fir_mac_slice #(
    .A_W   (DATA_SIZE + 1),
    .B_W   (COEF_SIZE),
    .ACC_W (ACC_SIZE)
  ) u_slice (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (rd_vld[RD_LAT-1]),
    .a     (samp),
    .b     ($signed(coef_q)),
    .acc   (acc)
  );

  // Widened by two bits so the rounding add and offset re-bias cannot wrap before saturation.
  always_comb begin
    y_rnd = (W'(acc) + RND) >>> COEF_FRAC;
    y_off = dc_lat ? (y_rnd + OFFS) : y_rnd;
    if (y_off < YMIN)      y_sat = '0;
    else if (y_off > YMAX) y_sat = YMAX[DATA_SIZE-1:0];
    else                   y_sat = y_off[DATA_SIZE-1:0];
  end

endmodule
